// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   MMIO request/response channel between the memory-access stage and the
//   I/O fabric. One request is outstanding at a time. Loads expect exactly
//   one response; stores do not get a response.
//   Signals:
//     io_req_valid  request present (held until io_req_ready)
//     io_req_ready  fabric accepts the request this cycle
//     io_we         1 = store, 0 = load
//     io_addr       full byte address
//     io_wdata      raw store data (no lane replication)
//     io_rsp_valid  load response present
//     io_rsp_data   load response data
interface mem_access_stage_if;
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_rsp_valid;
  logic [31:0] io_rsp_data;

  modport master (
    output io_req_valid, io_we, io_addr, io_wdata,
    input  io_req_ready, io_rsp_valid, io_rsp_data
  );

  modport slave (
    input  io_req_valid, io_we, io_addr, io_wdata,
    output io_req_ready, io_rsp_valid, io_rsp_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage. Ordinary loads/stores go to a synchronous
//   DMEM port in the same cycle. Accesses whose top nibble matches IO_REGION
//   are sent over the MMIO channel and stall the upstream stage until done.
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     ex_*                    execute-stage instruction (held while stall=1)
//     dmem_*                  DMEM port; dmem_dout arrives one cycle after dmem_en
//     io                      MMIO channel (master side)
//     stall                   upstream must hold ex_* while high
//     wb_*                    registered outputs to writeback
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | no MMIO transaction; normal accesses flow through
//   S_IO_REQ  | MMIO request driven, waiting for io_req_ready
//   S_IO_WAIT | MMIO load accepted, waiting for io_rsp_valid
module mem_access_stage #(
  parameter logic [3:0] IO_REGION = 4'h8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [31:0]         ex_pc,
  input  logic [31:0]         ex_inst,
  input  logic [31:0]         ex_alu,
  input  logic [31:0]         ex_rs2,
  input  logic [1:0]          ex_wbsel,
  output logic                dmem_en,
  output logic [3:0]          dmem_we,
  output logic [13:0]         dmem_addr,
  output logic [31:0]         dmem_din,
  input  logic [31:0]         dmem_dout,
  mem_access_stage_if.master  io,
  output logic                stall,
  output logic                wb_valid,
  output logic [31:0]         wb_pc,
  output logic [31:0]         wb_inst,
  output logic [31:0]         wb_alu,
  output logic [31:0]         wb_rdata,
  output logic [1:0]          wb_wbsel
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_IO_REQ, S_IO_WAIT} state_t;

  state_t      state_q;
  logic        req_valid_q;
  logic        io_we_q;
  logic [31:0] io_addr_q;
  logic [31:0] io_wdata_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_inst_q;
  logic [1:0]  hold_wbsel_q;
  logic        wb_valid_q;
  logic [31:0] wb_pc_q;
  logic [31:0] wb_inst_q;
  logic [31:0] wb_alu_q;
  logic [1:0]  wb_wbsel_q;
  logic [31:0] rdata_q;
  logic        sel_dmem_q;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        is_mmio;
  logic        mmio_detect;
  logic        io_done;
  logic [1:0]  width;
  logic [3:0]  be_raw;
  logic [31:0] din_rep;

  assign is_load     = (ex_inst[6:0] == OP_LOAD);
  assign is_store    = (ex_inst[6:0] == OP_STORE);
  assign width       = ex_inst[13:12];
  assign is_mem      = ex_valid & (is_load | is_store);
  assign is_mmio     = (ex_alu[31:28] == IO_REGION);
  assign mmio_detect = (state_q == S_IDLE) & is_mem & is_mmio;

  // Cycle in which the FSM goes back to IDLE: the MMIO instruction issues to
  // writeback on this edge, so the upstream stage may advance on it too.
  assign io_done = ((state_q == S_IO_REQ) & io.io_req_ready & io_we_q) |
                   ((state_q == S_IO_WAIT) & io.io_rsp_valid);

  assign stall = ~reset & (mmio_detect | ((state_q != S_IDLE) & ~io_done));

  // Byte lanes and replicated data; misaligned halfword/word stores write nothing.
  always_comb begin
    be_raw  = 4'b0000;
    din_rep = ex_rs2;
    case (width)
      2'b00: begin
        be_raw  = 4'b0001 << ex_alu[1:0];
        din_rep = {4{ex_rs2[7:0]}};
      end
      2'b01: begin
        be_raw  = ex_alu[0] ? 4'b0000 : (ex_alu[1] ? 4'b1100 : 4'b0011);
        din_rep = {2{ex_rs2[15:0]}};
      end
      2'b10: begin
        be_raw  = (ex_alu[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
        din_rep = ex_rs2;
      end
      default: begin
        be_raw  = 4'b0000;
        din_rep = ex_rs2;
      end
    endcase
  end

  assign dmem_en   = ~reset & is_mem & ~is_mmio & ~stall;
  assign dmem_we   = (dmem_en & is_store) ? be_raw : 4'b0000;
  assign dmem_addr = ex_alu[15:2];
  assign dmem_din  = din_rep;

  assign io.io_req_valid = req_valid_q & ~reset;
  assign io.io_we        = io_we_q;
  assign io.io_addr      = io_addr_q;
  assign io.io_wdata     = io_wdata_q;

  assign wb_valid = wb_valid_q;
  assign wb_pc    = wb_pc_q;
  assign wb_inst  = wb_inst_q;
  assign wb_alu   = wb_alu_q;
  assign wb_wbsel = wb_wbsel_q;
  // DMEM data is only available combinationally in the writeback cycle;
  // MMIO data was captured earlier and is held in rdata_q.
  assign wb_rdata = sel_dmem_q ? dmem_dout : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      io_we_q      <= 1'b0;
      io_addr_q    <= 32'h0;
      io_wdata_q   <= 32'h0;
      hold_pc_q    <= 32'h0;
      hold_inst_q  <= 32'h0;
      hold_wbsel_q <= 2'b00;
      wb_valid_q   <= 1'b0;
      wb_pc_q      <= 32'h0;
      wb_inst_q    <= 32'h0;
      wb_alu_q     <= 32'h0;
      wb_wbsel_q   <= 2'b00;
      rdata_q      <= 32'h0;
      sel_dmem_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mmio_detect) begin
            state_q      <= S_IO_REQ;
            req_valid_q  <= 1'b1;
            io_we_q      <= is_store;
            io_addr_q    <= ex_alu;
            io_wdata_q   <= ex_rs2;
            hold_pc_q    <= ex_pc;
            hold_inst_q  <= ex_inst;
            hold_wbsel_q <= ex_wbsel;
          end
        end
        S_IO_REQ: begin
          if (io.io_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= io_we_q ? S_IDLE : S_IO_WAIT;
          end
        end
        S_IO_WAIT: begin
          if (io.io_rsp_valid) begin
            rdata_q <= io.io_rsp_data;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (io_done) begin
        wb_valid_q <= 1'b1;
        wb_pc_q    <= hold_pc_q;
        wb_inst_q  <= hold_inst_q;
        wb_alu_q   <= io_addr_q;
        wb_wbsel_q <= hold_wbsel_q;
        sel_dmem_q <= 1'b0;
      end else if (stall) begin
        wb_valid_q <= 1'b0;
      end else begin
        wb_valid_q <= ex_valid;
        wb_pc_q    <= ex_pc;
        wb_inst_q  <= ex_inst;
        wb_alu_q   <= ex_alu;
        wb_wbsel_q <= ex_wbsel;
        sel_dmem_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_ADD = 32'h0000_0033;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_alu, ex_rs2;
  logic [1:0]  ex_wbsel;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [31:0] dmem_dout = 32'h0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_inst, wb_alu, wb_rdata;
  logic [1:0]  wb_wbsel;

  mem_access_stage_if io_bus();

  mem_access_stage #(.IO_REGION(4'h8)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_alu(ex_alu),
    .ex_rs2(ex_rs2), .ex_wbsel(ex_wbsel),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_din(dmem_din), .dmem_dout(dmem_dout),
    .io(io_bus),
    .stall(stall), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_alu(wb_alu), .wb_rdata(wb_rdata), .wb_wbsel(wb_wbsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // small synchronous DMEM: read-before-write, 16 words
  logic [31:0] mem [0:15] = '{default: 32'h0};
  always @(posedge clk) begin
    if (dmem_en) begin
      dmem_dout <= mem[dmem_addr[3:0]];
      for (int i = 0; i < 4; i++)
        if (dmem_we[i]) mem[dmem_addr[3:0]][8*i +: 8] <= dmem_din[8*i +: 8];
    end
  end

  int hs_cnt = 0;
  int we_cnt = 0;
  always @(posedge clk) begin
    if (io_bus.io_req_valid && io_bus.io_req_ready) hs_cnt <= hs_cnt + 1;
    if (dmem_we != 4'b0000) we_cnt <= we_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [1:0] sel);
    ex_valid = v; ex_pc = pc; ex_inst = inst; ex_alu = alu; ex_rs2 = rs2; ex_wbsel = sel;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h80, I_LW, 32'h8000_0004, 32'h0, 2'b10);
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (io_bus.io_req_valid !== 1'b0) begin bad++; $display("FAIL rst_io_req_valid got=%b exp=0", io_bus.io_req_valid); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
    total++; if ({wb_pc, wb_inst, wb_alu, wb_rdata} !== 128'h0) begin bad++; $display("FAIL rst_wb_fields got=%h %h %h %h exp=0", wb_pc, wb_inst, wb_alu, wb_rdata); end
    total++; if (wb_wbsel !== 2'b00) begin bad++; $display("FAIL rst_wb_wbsel got=%b exp=00", wb_wbsel); end
    drive(1'b1, 32'h84, I_SW, 32'h0000_1000, 32'h1, 2'b00);
    #1;
    total++; if (dmem_en !== 1'b0) begin bad++; $display("FAIL rst_dmem_en got=%b exp=0", dmem_en); end
    total++; if (dmem_we !== 4'b0000) begin bad++; $display("FAIL rst_dmem_we got=%b exp=0000", dmem_we); end
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    tick();
  endtask

  task automatic test_store_lanes();
    drive(1'b1, 32'h100, I_SB, 32'h0000_1002, 32'h0000_00AB, 2'b00);
    #1;
    total++; if (dmem_we !== 4'b0100) begin bad++; $display("FAIL sb_we got=%b exp=0100", dmem_we); end
    total++; if (dmem_din !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_din got=%h exp=ababab ab", dmem_din); end
    total++; if (dmem_addr !== 14'h400) begin bad++; $display("FAIL sb_addr got=%h exp=400", dmem_addr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_stall got=%b exp=0", stall); end
    total++; if (dmem_en !== 1'b1) begin bad++; $display("FAIL sb_en got=%b exp=1", dmem_en); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_pc !== 32'h100 || wb_alu !== 32'h1002) begin bad++; $display("FAIL sb_wb got=%b %h %h exp=1 100 1002", wb_valid, wb_pc, wb_alu); end
    drive(1'b1, 32'h104, I_SH, 32'h0000_1006, 32'hFFFF_1234, 2'b00);
    #1;
    total++; if (dmem_we !== 4'b1100 || dmem_din !== 32'h1234_1234) begin bad++; $display("FAIL sh_lane got=%b %h exp=1100 12341234", dmem_we, dmem_din); end
    tick();
    drive(1'b1, 32'h108, I_SW, 32'h0000_100C, 32'h1122_3344, 2'b00);
    #1;
    total++; if (dmem_we !== 4'b1111 || dmem_din !== 32'h1122_3344) begin bad++; $display("FAIL sw_lane got=%b %h exp=1111 11223344", dmem_we, dmem_din); end
    drive(1'b0, 32'h108, I_SW, 32'h0000_100C, 32'h1122_3344, 2'b00);
    #1;
    total++; if (dmem_we !== 4'b0000 || dmem_en !== 1'b0) begin bad++; $display("FAIL invalid_gate got=%b %b exp=0000 0", dmem_we, dmem_en); end
    tick();
  endtask

  task automatic test_misaligned();
    drive(1'b1, 32'h120, I_SH, 32'h0000_1001, 32'h0000_BEEF, 2'b00);
    #1;
    total++; if (dmem_we !== 4'b0000) begin bad++; $display("FAIL sh_mis_we got=%b exp=0000", dmem_we); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_pc !== 32'h120) begin bad++; $display("FAIL sh_mis_wb got=%b %h exp=1 120", wb_valid, wb_pc); end
    drive(1'b1, 32'h124, I_SW, 32'h0000_1002, 32'hFFFF_FFFF, 2'b00);
    #1;
    total++; if (dmem_we !== 4'b0000) begin bad++; $display("FAIL sw_mis_we got=%b exp=0000", dmem_we); end
    tick();
    drive(1'b1, 32'h128, I_LW, 32'h0000_1001, 32'h0, 2'b10);
    #1;
    total++; if (dmem_en !== 1'b1 || dmem_addr !== 14'h400) begin bad++; $display("FAIL lw_mis_en got=%b %h exp=1 400", dmem_en, dmem_addr); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    #1;
    // word 0 holds only the SB byte in lane 2; misaligned stores wrote nothing
    total++; if (wb_valid !== 1'b1 || wb_rdata !== 32'h00AB_0000) begin bad++; $display("FAIL lw_mis_rdata got=%b %h exp=1 00ab0000", wb_valid, wb_rdata); end
    tick();
  endtask

  task automatic test_mmio_load();
    int hs0;
    hs0 = hs_cnt;
    io_bus.io_req_ready = 1'b0;
    drive(1'b1, 32'h200, I_LW, 32'h8000_0010, 32'h0, 2'b10);
    #1;
    total++; if (stall !== 1'b1 || dmem_en !== 1'b0 || io_bus.io_req_valid !== 1'b0) begin bad++; $display("FAIL mld_detect got=%b %b %b exp=1 0 0", stall, dmem_en, io_bus.io_req_valid); end
    tick();
    total++; if (io_bus.io_req_valid !== 1'b1 || io_bus.io_addr !== 32'h8000_0010 || io_bus.io_we !== 1'b0) begin bad++; $display("FAIL mld_req got=%b %h %b exp=1 80000010 0", io_bus.io_req_valid, io_bus.io_addr, io_bus.io_we); end
    total++; if (stall !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL mld_req_stall got=%b %b exp=1 0", stall, wb_valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (io_bus.io_req_valid !== 1'b1 || io_bus.io_addr !== 32'h8000_0010 || stall !== 1'b1) begin bad++; $display("FAIL mld_hold%0d got=%b %h %b exp=1 80000010 1", i, io_bus.io_req_valid, io_bus.io_addr, stall); end
    end
    io_bus.io_req_ready = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mld_accept_stall got=%b exp=1", stall); end
    tick();
    io_bus.io_req_ready = 1'b0;
    total++; if (io_bus.io_req_valid !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL mld_wait got=%b %b %b exp=0 1 0", io_bus.io_req_valid, stall, wb_valid); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mld_wait2 got=%b exp=1", stall); end
    io_bus.io_rsp_valid = 1'b1;
    io_bus.io_rsp_data  = 32'hDEAD_BEEF;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mld_done_stall got=%b exp=0", stall); end
    tick();
    io_bus.io_rsp_valid = 1'b0;
    io_bus.io_rsp_data  = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    #1;
    total++; if (wb_valid !== 1'b1 || wb_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mld_wb got=%b %h exp=1 deadbeef", wb_valid, wb_rdata); end
    total++; if (wb_pc !== 32'h200 || wb_alu !== 32'h8000_0010 || wb_wbsel !== 2'b10 || wb_inst !== I_LW) begin bad++; $display("FAIL mld_wb_fields got=%h %h %b %h", wb_pc, wb_alu, wb_wbsel, wb_inst); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mld_after_stall got=%b exp=0", stall); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL mld_bubble got=%b exp=0", wb_valid); end
    total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL mld_hs_count got=%0d exp=1", hs_cnt - hs0); end
  endtask

  task automatic test_mmio_store();
    int hs0, we0;
    hs0 = hs_cnt;
    we0 = we_cnt;
    io_bus.io_req_ready = 1'b1;
    drive(1'b1, 32'h240, I_SW, 32'h8000_0008, 32'h0000_0055, 2'b00);
    #1;
    total++; if (stall !== 1'b1 || dmem_we !== 4'b0000) begin bad++; $display("FAIL mst_detect got=%b %b exp=1 0000", stall, dmem_we); end
    tick();
    total++; if (io_bus.io_req_valid !== 1'b1 || io_bus.io_we !== 1'b1 || io_bus.io_wdata !== 32'h55 || io_bus.io_addr !== 32'h8000_0008) begin bad++; $display("FAIL mst_req got=%b %b %h %h exp=1 1 55 80000008", io_bus.io_req_valid, io_bus.io_we, io_bus.io_wdata, io_bus.io_addr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mst_done_stall got=%b exp=0", stall); end
    tick();
    io_bus.io_req_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    #1;
    total++; if (wb_valid !== 1'b1 || wb_pc !== 32'h240 || io_bus.io_req_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mst_issue got=%b %h %b %b exp=1 240 0 0", wb_valid, wb_pc, io_bus.io_req_valid, stall); end
    tick();
    total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL mst_hs_count got=%0d exp=1", hs_cnt - hs0); end
    total++; if (we_cnt - we0 !== 0) begin bad++; $display("FAIL mst_dmem_we_count got=%0d exp=0", we_cnt - we0); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h2FC, I_SW, 32'h0000_1008, 32'hCAFE_F00D, 2'b00);
    tick();
    drive(1'b1, 32'h300, I_LW, 32'h0000_1008, 32'h0, 2'b10);
    #1;
    total++; if (stall !== 1'b0 || dmem_en !== 1'b1) begin bad++; $display("FAIL b2b_lw got=%b %b exp=0 1", stall, dmem_en); end
    tick();
    drive(1'b1, 32'h304, I_ADD, 32'h0000_0005, 32'h0, 2'b01);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_add_stall got=%b exp=0", stall); end
    total++; if (wb_valid !== 1'b1 || wb_pc !== 32'h300 || wb_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_lw_wb got=%b %h %h exp=1 300 cafef00d", wb_valid, wb_pc, wb_rdata); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    #1;
    total++; if (wb_valid !== 1'b1 || wb_pc !== 32'h304 || wb_alu !== 32'h5 || wb_wbsel !== 2'b01) begin bad++; $display("FAIL b2b_add_wb got=%b %h %h %b exp=1 304 5 01", wb_valid, wb_pc, wb_alu, wb_wbsel); end
    tick();
  endtask

  task automatic test_reset_io_wait();
    io_bus.io_req_ready = 1'b1;
    drive(1'b1, 32'h400, I_LW, 32'h8000_0020, 32'h0, 2'b10);
    tick();
    tick();
    io_bus.io_req_ready = 1'b0;
    #1;
    total++; if (stall !== 1'b1 || io_bus.io_req_valid !== 1'b0) begin bad++; $display("FAIL rw_in_wait got=%b %b exp=1 0", stall, io_bus.io_req_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    #1;
    total++; if (stall !== 1'b0 || wb_valid !== 1'b0 || io_bus.io_req_valid !== 1'b0) begin bad++; $display("FAIL rw_after_rst got=%b %b %b exp=0 0 0", stall, wb_valid, io_bus.io_req_valid); end
    io_bus.io_rsp_valid = 1'b1;
    io_bus.io_rsp_data  = 32'h1234_5678;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rw_late_rsp_stall got=%b exp=0", stall); end
    tick();
    io_bus.io_rsp_valid = 1'b0;
    total++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rw_late_rsp_ignored got=%b %b exp=0 0", wb_valid, stall); end
    drive(1'b1, 32'h500, I_ADD, 32'h0000_0009, 32'h0, 2'b01);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rw_add_stall got=%b exp=0", stall); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    total++; if (wb_valid !== 1'b1 || wb_pc !== 32'h500) begin bad++; $display("FAIL rw_add_wb got=%b %h exp=1 500", wb_valid, wb_pc); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    io_bus.io_req_ready = 1'b0;
    io_bus.io_rsp_valid = 1'b0;
    io_bus.io_rsp_data  = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    repeat (2) tick();
    test_reset();
    test_store_lanes();
    test_misaligned();
    test_mmio_load();
    test_mmio_store();
    test_back_to_back();
    test_reset_io_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
